fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1250, giving clocks per UART bit (12 MHz / 9600 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter DATA_W, default 3, giving the width of the FIFO words consumed.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port tx_en, input, 1, level; when high the block may pop new words.
REQ-006 Port fifo_empty, input, 1, upstream FIFO empty flag.
REQ-007 Port fifo_dout, input, DATA_W, upstream FIFO read data, valid the cycle after fifo_rd is high.
REQ-008 Port fifo_rd, output, 1, single-cycle read strobe to the upstream FIFO.
REQ-009 Port txd, output, 1, UART serial line, idle high.
REQ-010 Port busy, output, 1, high in every state except IDLE.
REQ-011 Port sent_cnt, output, 8, count of characters completed, wraps 255 to 0.

Function
REQ-012 The state machine SHALL have states IDLE, POP, LOAD, START, DATA, PAR, STOP.
REQ-013 IDLE SHALL go to POP when tx_en=1 and fifo_empty=0; otherwise it SHALL stay in IDLE.
REQ-014 fifo_rd SHALL be 1 only during the single POP cycle; POP SHALL always go to LOAD.
REQ-015 LOAD SHALL capture the character 8'h30 + zero-extended fifo_dout (ASCII digit) into the shift register, then go to START.
REQ-016 START SHALL drive txd=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, then go to PAR if parity is compiled in, else to STOP.
REQ-018 STOP SHALL drive txd=1 for CLKS_PER_BIT cycles, increment sent_cnt on its last cycle, then go to IDLE.
REQ-019 The bit timer SHALL count 0..CLKS_PER_BIT-1, and bit boundaries SHALL occur exactly at the terminal count.
REQ-020 txd SHALL be registered, and there SHALL be no combinational path from any input to txd.
REQ-021 Deassertion of tx_en mid-character SHALL NOT abort the character; it only blocks the next pop.
REQ-022 fifo_empty SHALL be sampled only in IDLE.
REQ-023 Back-to-back characters SHALL have a gap of exactly one IDLE cycle plus POP and LOAD, i.e. 3 cycles of txd=1 after STOP.
REQ-024 fifo_rd SHALL never be asserted while fifo_empty=1, and never more than once per character.

Reset
REQ-025 While rst=1 the block SHALL hold state=IDLE, txd=1, fifo_rd=0, busy=0, sent_cnt=0, and the bit timer, bit index and shift register at 0.
REQ-026 Reset asserted mid-character SHALL force txd=1 immediately, discard the character, and not increment sent_cnt.
REQ-027 After rst deasserts, the first pop SHALL occur no earlier than the second rising edge.

Configuration
REQ-028 Macro FIFO_UART_TX_PARITY_EN defined: PAR state SHALL send one even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP, giving 8E1 framing of 11 bit periods.
REQ-029 Macro undefined: PAR state and its logic SHALL be absent, giving 8N1 framing of 10 bit periods.

Verification (bench uses CLKS_PER_BIT=4)
REQ-030 Reset then idle with fifo_empty=1, tx_en=1 for 100 cycles -> txd=1, fifo_rd never high, busy=0, sent_cnt=0.
REQ-031 FIFO preloaded with 3'b001, 3'b010, 3'b011, 3'b100 -> exactly 4 fifo_rd pulses; txd frames decode to 0x31, 0x32, 0x33, 0x34; sent_cnt=4; busy falls after the 4th stop bit.
REQ-032 Single word 3'b101 -> start bit begins 2 cycles after fifo_rd; frame lasts 40 cycles (44 with FIFO_UART_TX_PARITY_EN); parity bit=0 for 0x35.
REQ-033 tx_en dropped during DATA of the first of 2 queued words -> first character completes, no second fifo_rd until tx_en returns high.
REQ-034 rst pulsed during bit 3 of DATA -> txd=1 asynchronously, sent_cnt unchanged at 0, and after release the next queued word transmits a full frame.
REQ-035 256 characters sent -> sent_cnt wraps to 0 on the 256th stop bit.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Pops 3-bit words from an upstream FIFO and transmits each as an ASCII digit over UART.
// Define FIFO_UART_TX_PARITY_EN for 8E1 framing; the default build sends 8N1.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              txd,
    output logic              busy,
    output logic [7:0]        sent_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PAR   = 3'd5,
`endif
        S_STOP  = 3'd6
    } state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    function automatic logic [7:0] ascii_digit(input logic [DATA_W-1:0] w);
        return 8'h30 + 8'(w);
    endfunction

`ifdef FIFO_UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        txd_q, txd_d;
    logic        rd_q;
    logic        busy_q;
    logic        rdy_q;
    logic        bit_done;
`ifdef FIFO_UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    assign bit_done = (timer_q == BIT_LAST);

    // Next-state, bit timing and serial-line value for the following cycle.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        txd_d     = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                // rdy_q holds off the first pop until the second edge after reset
                if (rdy_q && tx_en && !fifo_empty) begin
                    state_d = S_POP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d   = ascii_digit(fifo_dout);
`ifdef FIFO_UART_TX_PARITY_EN
                par_d     = even_parity(shift_d);
`endif
                timer_d   = 16'd0;
                bit_idx_d = 3'd0;
                state_d   = S_START;
            end
            S_START: begin
                if (bit_done) begin
                    timer_d = 16'd0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    timer_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PAR: begin
                if (bit_done) begin
                    timer_d = 16'd0;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    timer_d = 16'd0;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // txd is decoded from the next state so the register lines up with the state
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PAR:   txd_d = par_q;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            cnt_q     <= 8'd0;
            txd_q     <= 1'b1;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            txd_q     <= txd_d;
            rd_q      <= (state_d == S_POP);
            busy_q    <= (state_d != S_IDLE);
            rdy_q     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign fifo_rd  = rd_q;
    assign txd      = txd_q;
    assign busy     = busy_q;
    assign sent_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, UART frame decoder and expected-character queues.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [2:0] fifo_dout = 3'd0;
    logic       fifo_rd;
    logic       txd;
    logic       busy;
    logic [7:0] sent_cnt;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(3)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .txd(txd), .busy(busy),
        .sent_cnt(sent_cnt)
    );

    typedef struct {
        logic [2:0] word;
        logic [7:0] ch;
        logic       par;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [2:0] fq[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         starts_q[$];
    int         rd_total = 0;
    int         rd_empty_err = 0;
    int         frame_err = 0;
    int         rd_cyc = 0;
    int         start_cyc = 0;
    int         busy_fall_cyc = 0;
    logic       last_par = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (k < budget && !(rx_q.size() >= n && busy === 1'b0)) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_timeout"}, (k < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_start(input int budget, input string nm);
        int k;
        k = 0;
        while (k < budget && txd !== 1'b0) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_timeout"}, (k < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Upstream FIFO model and UART line decoder, both sampled on the falling edge.
    initial begin : monitor
        bit          in_frame;
        int          pos;
        int          bk;
        logic [10:0] bits;
        logic [7:0]  data;
        logic        busy_prev;
        in_frame = 1'b0;
        pos = 0;
        bits = 11'd0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (fifo_rd === 1'b1) begin
                rd_total++;
                rd_cyc = cyc;
                if (fifo_empty) rd_empty_err++;
                if (fq.size() > 0) fifo_dout = fq.pop_front();
            end
            fifo_empty = (fq.size() == 0);
            if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
            busy_prev = busy;
            if (rst) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (txd === 1'b0) begin
                    in_frame = 1'b1;
                    pos = 0;
                    start_cyc = cyc;
                    starts_q.push_back(cyc);
                end
            end else begin
                pos++;
            end
            if (in_frame && (pos % CPB) == CPB / 2) begin
                bk = pos / CPB;
                bits[bk] = txd;
                if (bk == NB - 1) begin
                    data = bits[8:1];
                    if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) frame_err++;
`ifdef FIFO_UART_TX_PARITY_EN
                    if (bits[9] !== ^data) frame_err++;
                    last_par = bits[9];
`endif
                    rx_q.push_back(data);
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t       vt[8];
        logic [7:0] exp4[4];
        int         rd0;
        int         low;
        int         bz;
        int         w;
        int         gap;
        int         exp_cnt;

        vt[0] = '{3'd0, 8'h30, 1'b0};
        vt[1] = '{3'd1, 8'h31, 1'b1};
        vt[2] = '{3'd2, 8'h32, 1'b1};
        vt[3] = '{3'd3, 8'h33, 1'b0};
        vt[4] = '{3'd4, 8'h34, 1'b1};
        vt[5] = '{3'd5, 8'h35, 1'b0};
        vt[6] = '{3'd6, 8'h36, 1'b0};
        vt[7] = '{3'd7, 8'h37, 1'b1};
        exp4 = '{8'h31, 8'h32, 8'h33, 8'h34};

        rst = 1'b1;
        tx_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_rd", 32'(fifo_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(sent_cnt), 32'd0);

        // Idle with an empty FIFO
        rst = 1'b0;
        tx_en = 1'b1;
        rd0 = rd_total;
        low = 0;
        bz = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1) low++;
            if (busy !== 1'b0) bz++;
        end
        chk("idle_txd_low", 32'(low), 32'd0);
        chk("idle_busy", 32'(bz), 32'd0);
        chk("idle_rd", 32'(rd_total - rd0), 32'd0);
        chk("idle_cnt", 32'(sent_cnt), 32'd0);

        // Word queued across reset release, then single-frame timing
        rst = 1'b1;
        fq.push_back(3'd5);
        repeat (2) @(negedge clk);
        rx_q.delete();
        rd0 = rd_total;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_first_edge_rd", 32'(fifo_rd), 32'd0);
        wait_done(1, 150, "single");
        chk("single_rd", 32'(rd_total - rd0), 32'd1);
        chk("single_ch", 32'(rx_q[0]), 32'h35);
        chk("single_start_lat", 32'(start_cyc - rd_cyc), 32'd2);
        chk("single_frame_len", 32'(busy_fall_cyc - start_cyc), 32'(CPB * NB));
`ifdef FIFO_UART_TX_PARITY_EN
        chk("single_par", 32'(last_par), 32'd0);
`endif
        chk("single_cnt", 32'(sent_cnt), 32'd1);

        // Four preloaded words back to back
        do_reset();
        rx_q.delete();
        starts_q.delete();
        rd0 = rd_total;
        for (int i = 0; i < 4; i++) fq.push_back(3'(i + 1));
        wait_done(4, 300, "four");
        chk("four_rd", 32'(rd_total - rd0), 32'd4);
        chk("four_rx_n", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("four_ch%0d", i), 32'(rx_q[i]), 32'(exp4[i]));
        chk("four_cnt", 32'(sent_cnt), 32'd4);
        chk("four_busy", 32'(busy), 32'd0);
        chk("four_last_len", 32'(busy_fall_cyc - starts_q[3]), 32'(CPB * NB));
        for (int i = 1; i < 4; i++)
            chk($sformatf("four_gap%0d", i), 32'(starts_q[i] - starts_q[i-1]), 32'(CPB * NB + 3));
        exp_cnt = 4;

        // Table of every digit
        for (int i = 0; i < 8; i++) begin
            rx_q.delete();
            fq.push_back(vt[i].word);
            wait_done(1, 150, $sformatf("vec%0d", i));
            exp_cnt++;
            chk($sformatf("vec%0d_ch", i), 32'(rx_q[0]), 32'(vt[i].ch));
`ifdef FIFO_UART_TX_PARITY_EN
            chk($sformatf("vec%0d_par", i), 32'(last_par), 32'(vt[i].par));
`endif
            chk($sformatf("vec%0d_cnt", i), 32'(sent_cnt), 32'(exp_cnt % 256));
        end

        // tx_en dropped mid-character
        rx_q.delete();
        rd0 = rd_total;
        fq.push_back(3'd2);
        fq.push_back(3'd3);
        wait_start(30, "ten_start");
        repeat (2 * CPB) @(negedge clk);
        tx_en = 1'b0;
        repeat (120) @(negedge clk);
        chk("ten_rd_held", 32'(rd_total - rd0), 32'd1);
        chk("ten_rx_n", 32'(rx_q.size()), 32'd1);
        chk("ten_ch0", 32'(rx_q[0]), 32'h32);
        chk("ten_busy", 32'(busy), 32'd0);
        chk("ten_cnt1", 32'(sent_cnt), 32'((exp_cnt + 1) % 256));
        tx_en = 1'b1;
        wait_done(2, 150, "ten_resume");
        chk("ten_rd_total", 32'(rd_total - rd0), 32'd2);
        chk("ten_ch1", 32'(rx_q[1]), 32'h33);
        exp_cnt += 2;
        chk("ten_cnt2", 32'(sent_cnt), 32'(exp_cnt % 256));

        // Reset during data bit 3
        do_reset();
        rx_q.delete();
        fq.push_back(3'd6);
        fq.push_back(3'd7);
        wait_start(30, "mrst_start");
        repeat (CPB * 4 + 1) @(negedge clk);
        chk("mrst_pre_txd", 32'(txd), 32'd0);
        rst = 1'b1;
        #1;
        chk("mrst_txd", 32'(txd), 32'd1);
        chk("mrst_cnt", 32'(sent_cnt), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_done(1, 200, "mrst_next");
        chk("mrst_rx_n", 32'(rx_q.size()), 32'd1);
        chk("mrst_ch", 32'(rx_q[0]), 32'h37);
        chk("mrst_len", 32'(busy_fall_cyc - start_cyc), 32'(CPB * NB));
        chk("mrst_cnt_after", 32'(sent_cnt), 32'd1);

        // Randomized words with random tx_en toggling
        do_reset();
        rx_q.delete();
        exp_q.delete();
        rd0 = rd_total;
        for (int i = 0; i < 16; i++) begin
            w = $urandom_range(0, 7);
            fq.push_back(3'(w));
            exp_q.push_back(8'h30 + 8'(w));
            gap = $urandom_range(0, 60);
            repeat (gap) begin
                @(negedge clk);
                tx_en = 1'($urandom_range(0, 1));
            end
        end
        tx_en = 1'b1;
        wait_done(16, 16 * 60, "rand");
        chk("rand_rx_n", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk($sformatf("rand_ch%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        chk("rand_rd", 32'(rd_total - rd0), 32'd16);
        chk("rand_cnt", 32'(sent_cnt), 32'd16);

        // Counter wrap after 256 characters
        do_reset();
        rx_q.delete();
        for (int i = 0; i < 255; i++) fq.push_back(3'(i % 8));
        wait_done(255, 255 * 50, "wrap255");
        chk("wrap_cnt255", 32'(sent_cnt), 32'd255);
        fq.push_back(3'd3);
        wait_done(256, 150, "wrap256");
        chk("wrap_cnt0", 32'(sent_cnt), 32'd0);
        chk("wrap_rx_n", 32'(rx_q.size()), 32'd256);
        chk("wrap_last_ch", 32'(rx_q[255]), 32'h33);

        chk("rd_while_empty", 32'(rd_empty_err), 32'd0);
        chk("frame_errors", 32'(frame_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
